// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring on magnitudes) unit.
// One iteration per clock; result parked in Zhigh/Zlow with a one-cycle done pulse.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] BusMuxOut,
  input  logic             Yin,
  input  logic             start,
  input  logic             op,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] ZhighBusIn,
  output logic [WIDTH-1:0] zlowBusIn
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] a_copy;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] q;
  logic [WIDTH:0]   acc;
  logic             q_1;
  logic             op_q;
  logic             sign_a;
  logic             sign_b;
  logic [CW-1:0]    count;

  logic             last;
  logic             accept;
  logic             bus_zero;
  logic [WIDTH-1:0] y_abs;
  logic [WIDTH-1:0] bus_abs;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   booth_acc;
  logic [WIDTH-1:0] booth_q;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   div_acc;
  logic [WIDTH-1:0] div_q;

  assign last     = (count == CW'(WIDTH - 1));
  assign accept   = (state == S_IDLE) && start;
  assign bus_zero = (BusMuxOut == '0);
  assign y_abs    = y[WIDTH-1] ? -y : y;
  assign bus_abs  = BusMuxOut[WIDTH-1] ? -BusMuxOut : BusMuxOut;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = (op && bus_zero) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last) begin
          state_nxt = op_q ? S_FIX : S_DONE;
        end
      end
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Booth step: add/subtract on {q[0], q_1}, then arithmetic shift of {acc, q, q_1}.
  always_comb begin
    m_ext     = {m[WIDTH-1], m};
    booth_sum = acc;
    case ({q[0], q_1})
      2'b01:   booth_sum = acc + m_ext;
      2'b10:   booth_sum = acc - m_ext;
      default: booth_sum = acc;
    endcase
    booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    booth_q   = {booth_sum[0], q[WIDTH-1:1]};
  end

  // Restoring step: shift dividend bit into remainder, keep the trial if it didn't borrow.
  always_comb begin
    rem_shift = {acc[WIDTH-1:0], q[WIDTH-1]};
    trial     = {1'b0, rem_shift} - {2'b00, m};
    div_acc   = trial[WIDTH+1] ? rem_shift : trial[WIDTH:0];
    div_q     = {q[WIDTH-2:0], ~trial[WIDTH+1]};
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      y          <= '0;
      a_copy     <= '0;
      m          <= '0;
      q          <= '0;
      acc        <= '0;
      q_1        <= 1'b0;
      op_q       <= 1'b0;
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
      ZhighBusIn <= '0;
      zlowBusIn  <= '0;
    end else begin
      done <= 1'b0;
      if (Yin) begin
        y <= BusMuxOut;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q     <= op;
            sign_a   <= y[WIDTH-1];
            sign_b   <= BusMuxOut[WIDTH-1];
            a_copy   <= y;
            acc      <= '0;
            q_1      <= 1'b0;
            count    <= '0;
            busy     <= 1'b1;
            div_zero <= 1'b0;
            // Divide works on magnitudes; multiply keeps signed operands for Booth.
            m        <= op ? bus_abs : y;
            q        <= op ? y_abs : BusMuxOut;
          end
        end
        S_RUN: begin
          count <= count + 1'b1;
          if (op_q) begin
            acc <= div_acc;
            q   <= div_q;
          end else begin
            acc <= booth_acc;
            q   <= booth_q;
            q_1 <= q[0];
          end
        end
        S_FIX: begin
          if (sign_a ^ sign_b) begin
            q <= -q;
          end
          if (sign_a) begin
            acc <= -acc;
          end
        end
        S_DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (op_q && (m == '0)) begin
            ZhighBusIn <= a_copy;
            zlowBusIn  <= '1;
            div_zero   <= 1'b1;
          end else begin
            ZhighBusIn <= acc[WIDTH-1:0];
            zlowBusIn  <= q;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and random checks of mul_div_unit against a plain-arithmetic reference.
module tb_mul_div_unit;

  logic        clock;
  logic        clear;
  logic [31:0] BusMuxOut;
  logic        Yin;
  logic        start;
  logic        op;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] ZhighBusIn;
  logic [31:0] zlowBusIn;

  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] y_model;

  mul_div_unit #(.WIDTH(32)) dut (
    .clock      (clock),
    .clear      (clear),
    .BusMuxOut  (BusMuxOut),
    .Yin        (Yin),
    .start      (start),
    .op         (op),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .ZhighBusIn (ZhighBusIn),
    .zlowBusIn  (zlowBusIn)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic ref_model(input logic [31:0] a, input logic [31:0] b, input logic opv,
                           output logic [31:0] hi, output logic [31:0] lo,
                           output logic dz, output int lat);
    longint la, lb, r;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    if (!opv) begin
      r   = la * lb;
      hi  = r[63:32];
      lo  = r[31:0];
      dz  = 1'b0;
      lat = 33;
    end else if (b == 32'd0) begin
      hi  = a;
      lo  = 32'hFFFF_FFFF;
      dz  = 1'b1;
      lat = 1;
    end else begin
      r   = la / lb;
      lo  = r[31:0];
      r   = la % lb;
      hi  = r[31:0];
      dz  = 1'b0;
      lat = 34;
    end
  endtask

  task automatic load_y(input logic [31:0] v);
    Yin       = 1'b1;
    BusMuxOut = v;
    tick;
    Yin       = 1'b0;
    y_model   = v;
  endtask

  // inj_kind: 1 = stray start mid-op, 2 = Yin with bus=9 mid-op
  task automatic run_op(input string tag, input logic [31:0] b, input logic opv,
                        input logic y_same, input int inj_at, input int inj_kind);
    logic [31:0] ehi, elo;
    logic        edz;
    int          elat, n, bcnt;
    ref_model(y_model, b, opv, ehi, elo, edz, elat);
    if (y_same) y_model = b;
    BusMuxOut = b;
    op        = opv;
    start     = 1'b1;
    Yin       = y_same;
    tick;
    start = 1'b0;
    Yin   = 1'b0;
    chk({tag, "_dz_cleared"}, 64'(div_zero), 64'(0));
    n    = 0;
    bcnt = 0;
    while (!done && n < 60) begin
      if (busy) bcnt++;
      if (n == inj_at) begin
        if (inj_kind == 1) begin
          start     = 1'b1;
          BusMuxOut = 32'h0000_0005;
          op        = ~opv;
        end else if (inj_kind == 2) begin
          Yin       = 1'b1;
          BusMuxOut = 32'd9;
          y_model   = 32'd9;
        end
      end
      tick;
      start = 1'b0;
      Yin   = 1'b0;
      n++;
    end
    chk({tag, "_latency"},  64'(n),        64'(elat));
    chk({tag, "_busy_cyc"}, 64'(bcnt),     64'(elat));
    chk({tag, "_busy_low"}, 64'(busy),     64'(0));
    chk({tag, "_zhigh"},    64'(ZhighBusIn), 64'(ehi));
    chk({tag, "_zlow"},     64'(zlowBusIn),  64'(elo));
    chk({tag, "_div_zero"}, 64'(div_zero), 64'(edz));
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rop;
    int          sel;

    clear     = 1'b0;
    Yin       = 1'b0;
    start     = 1'b0;
    op        = 1'b0;
    BusMuxOut = 32'd0;
    y_model   = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_dz",   64'(div_zero), 64'(0));
    chk("reset_z",    {ZhighBusIn, zlowBusIn}, 64'(0));
    clear = 1'b1;
    tick;

    load_y(32'd12);          run_op("mul_12x3",    32'd3, 1'b0, 1'b0, -1, 0);
    load_y(-32'sd7);         run_op("mul_n7x5",    32'd5, 1'b0, 1'b0, -1, 0);
    load_y(32'h8000_0000);   run_op("mul_min_sq",  32'h8000_0000, 1'b0, 1'b0, -1, 0);
    load_y(-32'sd17);        run_op("div_n17_5",   32'd5, 1'b1, 1'b0, -1, 0);
    load_y(32'd17);          run_op("div_17_n5",   -32'sd5, 1'b1, 1'b0, -1, 0);
    load_y(32'h8000_0000);   run_op("div_min_n1",  32'hFFFF_FFFF, 1'b1, 1'b0, -1, 0);
    load_y(32'd100);         run_op("div_by_zero", 32'd0, 1'b1, 1'b0, -1, 0);
    run_op("b2b_100_7", 32'd7, 1'b1, 1'b0, -1, 0);
    run_op("b2b_100_x3", 32'd3, 1'b0, 1'b0, -1, 0);

    load_y(32'd12);          run_op("mul_ign_start", 32'd3, 1'b0, 1'b0, 5, 1);
    load_y(32'd12);          run_op("mul_yin_mid",   32'd3, 1'b0, 1'b0, 7, 2);
    run_op("y_after_mid", 32'd2, 1'b0, 1'b0, -1, 0);
    load_y(32'd4);           run_op("y_with_start",  32'd11, 1'b0, 1'b1, -1, 0);
    run_op("y_new_value", 32'd1, 1'b0, 1'b0, -1, 0);

    load_y(-32'sd50);
    BusMuxOut = 32'd7;
    op        = 1'b1;
    start     = 1'b1;
    tick;
    start = 1'b0;
    repeat (10) tick;
    chk("pre_rst_busy", 64'(busy), 64'(1));
    clear = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_dz",   64'(div_zero), 64'(0));
    chk("rst_z",    {ZhighBusIn, zlowBusIn}, 64'(0));
    #3;
    clear   = 1'b1;
    y_model = 32'd0;
    tick;
    run_op("post_rst_y0",  32'd7, 1'b0, 1'b0, -1, 0);
    load_y(32'd6);
    run_op("post_rst_6x7", 32'd7, 1'b0, 1'b0, -1, 0);

    for (int i = 0; i < 16; i++) begin
      ra  = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'h8000_0000;
        3:       rb = 32'(($urandom_range(0, 15))) - 32'd8;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      rop = 1'($urandom_range(0, 1));
      load_y(ra);
      run_op("random", rb, rop, 1'b0, -1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
